// File: rtl/i2s_tx_framer_pkg.sv
// i2s_tx_framer_pkg: shared FSM state type and default build parameters for the DAC transmitter
package i2s_tx_framer_pkg;
  localparam int DAC_WIDTH = 24;
  localparam int DAC_N_CHANNELS = 2;
  localparam int DAC_BCLK_DIV = 8;
  typedef enum logic {IDLE, RUN} i2s_state_t;
endpackage

// File: rtl/i2s_tx_framer_bclk_divider.sv
// i2s_tx_framer_bclk_divider: sclk generator and bit-edge pulse, held cleared while not running
module i2s_tx_framer_bclk_divider #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic sclk,
  output logic bit_edge
);
  localparam int CW = $clog2(BCLK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BCLK_DIV / 2);
  logic [CW-1:0] cnt_q, cnt_d;
  logic sclk_q, sclk_d;
  always_comb begin
    bit_edge = run & (cnt_q == C_LAST);
    cnt_d = (!run || bit_edge) ? '0 : cnt_q + CW'(1);
    sclk_d = cnt_d >= C_HALF;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
  assign sclk = sclk_q;
endmodule

// File: rtl/i2s_tx_framer.sv
// i2s_tx_framer: multi-channel I2S DAC transmitter with double-buffered frames and underrun reporting
// Build option: I2S_TX_UNDERRUN_HOLD_EN retransmits the last loaded frame on underrun.
module i2s_tx_framer
  import i2s_tx_framer_pkg::*;
#(
  parameter int WIDTH = DAC_WIDTH,
  parameter int N_CHANNELS = DAC_N_CHANNELS,
  parameter int BCLK_DIV = DAC_BCLK_DIV
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [N_CHANNELS*WIDTH-1:0]   sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          frame_strobe,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          sclk,
  output logic                          lrclk,
  output logic                          sd
);
  localparam int FB = N_CHANNELS * WIDTH;
  localparam int KW = $clog2(FB);
  localparam logic [KW-1:0] K_LAST = KW'(FB - 1);
  localparam logic [KW-1:0] K_HALF = KW'(FB / 2);
  i2s_state_t state_q, state_d;
  logic [FB-1:0] hold_q, hold_d, shift_q, shift_d, src, fill, ordered;
  logic [KW-1:0] k_q, k_d, k_n;
  logic hold_full_q, hold_full_d, lrclk_q, lrclk_d;
  logic frame_strobe_q, frame_strobe_d, underrun_q, underrun_d;
  logic bit_edge, load_now, stop, xfer;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [FB-1:0] last_q, last_d;
`endif
  i2s_tx_framer_bclk_divider #(.BCLK_DIV(BCLK_DIV)) u_div (
    .clk(clk),
    .rstn(rstn),
    .run(state_q == RUN),
    .sclk(sclk),
    .bit_edge(bit_edge)
  );
  always_comb begin
    load_now = enable & ((state_q == IDLE) | (bit_edge & (k_q == K_LAST)));
    stop = ~enable & bit_edge & (k_q == K_LAST);
    sample_ready = ~hold_full_q | load_now;
    xfer = sample_valid & sample_ready;
    hold_d = xfer ? sample_in : hold_q;
    hold_full_d = xfer | (hold_full_q & ~load_now);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    fill = last_q;
`else
    fill = '0;
`endif
    src = hold_full_q ? hold_q : fill;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    last_d = load_now ? src : last_q;
`endif
    // channel 0 sits in the low bits of the input but must leave the shifter first
    ordered = '0;
    for (int c = 0; c < N_CHANNELS; c++)
      ordered[(N_CHANNELS-1-c)*WIDTH +: WIDTH] = src[c*WIDTH +: WIDTH];
    shift_d = load_now ? ordered : stop ? '0 : bit_edge ? shift_q << 1 : shift_q;
    k_d = (load_now | stop) ? '0 : bit_edge ? k_q + KW'(1) : k_q;
    k_n = (k_d == K_LAST) ? '0 : k_d + KW'(1);
    lrclk_d = stop ? 1'b0 : (load_now | bit_edge) ? (k_n >= K_HALF) : lrclk_q;
    state_d = load_now ? RUN : stop ? IDLE : state_q;
    underrun_d = (load_now & ~hold_full_q) | (underrun_q & ~underrun_clr);
    frame_strobe_d = load_now;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      shift_q <= '0;
      k_q <= '0;
      lrclk_q <= 1'b0;
      frame_strobe_q <= 1'b0;
      underrun_q <= 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      last_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q <= shift_d;
      k_q <= k_d;
      lrclk_q <= lrclk_d;
      frame_strobe_q <= frame_strobe_d;
      underrun_q <= underrun_d;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      last_q <= last_d;
`endif
    end
  end
  assign sd = shift_q[FB-1];
  assign lrclk = lrclk_q;
  assign frame_strobe = frame_strobe_q;
  assign underrun = underrun_q;
endmodule
